// File: rtl/nec_pkg.sv
// Shared types and constants for the NEC IR transmitter: FSM states, unit counts, 50 MHz defaults.
package nec_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark
    } nec_state_e;

    localparam int unsigned DefUnitCyc = 28125;
    localparam int unsigned DefCarHalf = 658;

    localparam int unsigned LeadMarkU  = 16;
    localparam int unsigned LeadSpaceU = 8;
    localparam int unsigned RptSpaceU  = 4;
    localparam int unsigned BitMarkU   = 1;
    localparam int unsigned BitSpace0U = 1;
    localparam int unsigned BitSpace1U = 3;
    localparam int unsigned StopMarkU  = 1;

    // Bit 0 goes on air first, so the address sits in the low byte.
    function automatic logic [31:0] nec_frame(input logic [7:0] addr, input logic [7:0] cmd);
        return {~cmd, cmd, ~addr, addr};
    endfunction

endpackage

// File: rtl/nec_ir_tx_if.sv
// Request/status bundle between a frame requester and the NEC transmitter.
interface nec_ir_tx_if;
    logic       Start;
    logic       Repeat;
    logic [7:0] Addr;
    logic [7:0] Cmd;
    logic       IrOut;
    logic       Envelope;
    logic       Busy;
    logic       Done;

    modport master (
        output Start, Repeat, Addr, Cmd,
        input  IrOut, Envelope, Busy, Done
    );

    modport slave (
        input  Start, Repeat, Addr, Cmd,
        output IrOut, Envelope, Busy, Done
    );
endinterface

// File: rtl/nec_carrier_gen.sv
// Carrier phase generator; restart forces phase high with a fresh count on mark entry.
module nec_carrier_gen
    import nec_pkg::*;
#(
    parameter int unsigned CAR_HALF = DefCarHalf
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic phase
);

    localparam int unsigned CW = (CAR_HALF > 1) ? $clog2(CAR_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (en) begin
            if (cnt_q == CW'(CAR_HALF - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/nec_ir_tx.sv
// NEC IR transmitter: unit timebase and frame FSM emitting a full frame or a repeat code.
module nec_ir_tx
    import nec_pkg::*;
#(
    parameter int unsigned UNIT_CYC     = DefUnitCyc,
    parameter int unsigned CAR_HALF     = DefCarHalf,
    parameter int unsigned LEAD_MARK_U  = LeadMarkU,
    parameter int unsigned LEAD_SPACE_U = LeadSpaceU,
    parameter int unsigned RPT_SPACE_U  = RptSpaceU
) (
    input  logic        CLK,
    input  logic        RST_n,
    nec_ir_tx_if.slave  bus
);

    localparam int unsigned UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;

    nec_state_e    state_q, state_d;
    logic [UW-1:0] unit_cnt_q, unit_cnt_d;
    logic [4:0]    units_q, units_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [31:0]   frame_q, frame_d;
    logic          rpt_q, rpt_d;
    logic          done_q, done_d;
    logic [4:0]    dur;
    logic          tick, last, mark_entry, envelope, phase;

    assign tick = (unit_cnt_q == UW'(UNIT_CYC - 1));

    // Length of the current state in units.
    always_comb begin
        dur = 5'd1;
        unique case (state_q)
            StLeadMark:  dur = 5'(LEAD_MARK_U);
            StLeadSpace: dur = rpt_q ? 5'(RPT_SPACE_U) : 5'(LEAD_SPACE_U);
            StBitMark:   dur = 5'(BitMarkU);
            StBitSpace:  dur = frame_q[bit_idx_q] ? 5'(BitSpace1U) : 5'(BitSpace0U);
            StStopMark:  dur = 5'(StopMarkU);
            default:     dur = 5'd1;
        endcase
    end

    assign last = tick && (units_q == dur - 5'd1);

    always_comb begin
        state_d    = state_q;
        unit_cnt_d = unit_cnt_q;
        units_d    = units_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        rpt_d      = rpt_q;
        done_d     = 1'b0;
        mark_entry = 1'b0;

        if (state_q != StIdle) begin
            if (tick) begin
                unit_cnt_d = '0;
                units_d    = units_q + 5'd1;
            end else begin
                unit_cnt_d = unit_cnt_q + UW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d    = StLeadMark;
                    frame_d    = nec_frame(bus.Addr, bus.Cmd);
                    rpt_d      = bus.Repeat;
                    mark_entry = 1'b1;
                end
            end
            StLeadMark: begin
                if (last) state_d = StLeadSpace;
            end
            StLeadSpace: begin
                if (last) begin
                    state_d    = rpt_q ? StStopMark : StBitMark;
                    bit_idx_d  = '0;
                    mark_entry = 1'b1;
                end
            end
            StBitMark: begin
                if (last) state_d = StBitSpace;
            end
            StBitSpace: begin
                if (last) begin
                    mark_entry = 1'b1;
                    if (bit_idx_q == 5'd31) begin
                        state_d = StStopMark;
                    end else begin
                        state_d   = StBitMark;
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            StStopMark: begin
                if (last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Every state starts its timebase from zero.
        if (state_d != state_q) begin
            unit_cnt_d = '0;
            units_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q    <= StIdle;
            unit_cnt_q <= '0;
            units_q    <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '0;
            rpt_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            units_q    <= units_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            rpt_q      <= rpt_d;
            done_q     <= done_d;
        end
    end

    assign envelope = (state_q == StLeadMark) || (state_q == StBitMark) ||
                      (state_q == StStopMark);

    nec_carrier_gen #(
        .CAR_HALF (CAR_HALF)
    ) u_carrier (
        .clk     (CLK),
        .rst_n   (RST_n),
        .en      (envelope),
        .restart (mark_entry),
        .phase   (phase)
    );

    assign bus.Envelope = envelope;
    assign bus.IrOut    = envelope & phase;
    assign bus.Busy     = (state_q != StIdle);
    assign bus.Done     = done_q;

endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
- NEC infrared remote transmitter: the sending end of the IR link whose received 32-bit frames drive the motor on/off and speed controls.
- Takes an 8-bit address and 8-bit command and emits a full NEC frame or an NEC repeat code.
- Provides both the 38 kHz-modulated output for an IR LED driver and the unmodulated envelope.
- Used as a test stimulus source and for board-to-board control.

Parameters:
- UNIT_CYC, 28125, CLK cycles per NEC time unit of 562.5 us (28125 at 50 MHz).
- CAR_HALF, 658, CLK cycles per carrier half-period (about 38 kHz at 50 MHz).
- LEAD_MARK_U, 16, leader mark length in units (9 ms).
- LEAD_SPACE_U, 8, leader space length in units for a full frame (4.5 ms).
- RPT_SPACE_U, 4, leader space length in units for a repeat code (2.25 ms).

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  synchronous reset, active low.
- Start  in  1  single-cycle request; sampled only in IDLE.
- Repeat  in  1  qualifier sampled with Start; 1 sends the repeat code, 0 sends the full frame.
- Addr  in  8  NEC address; latched on an accepted Start.
- Cmd  in  8  NEC command; latched on an accepted Start.
- IrOut  out  1  carrier-modulated output.
- Envelope  out  1  unmodulated mark (1) / space (0).
- Busy  out  1  high from the cycle after an accepted Start through the last stop-mark cycle.
- Done  out  1  one-cycle pulse in the cycle after the stop mark ends.

Behaviour:
- Reset (RST_n=0 at a CLK edge): state IDLE; IrOut, Envelope, Busy and Done all 0; all counters 0.
  - Reset mid-frame aborts the frame immediately.
  - No Done pulse is generated for an aborted frame.
- Frame word: F = {~Cmd, Cmd, ~Addr, Addr}, sent bit 0 first. The receiver therefore sees the command in F[23:16] and its complement in F[31:24].
- Timebase:
  - The unit counter counts 0..UNIT_CYC-1 and wraps.
  - A unit tick fires on wrap.
  - The unit counter is cleared on every state entry.
  - Each state lasts exactly N units, i.e. N*UNIT_CYC cycles.
- States and durations:
  - IDLE: waits for Start.
  - LEAD_MARK: LEAD_MARK_U units.
  - LEAD_SPACE: LEAD_SPACE_U units, or RPT_SPACE_U units for a repeat code.
  - BIT_MARK: 1 unit.
  - BIT_SPACE: 1 unit for a 0 bit, 3 units for a 1 bit.
  - STOP_MARK: 1 unit.
- Transitions:
  - IDLE → LEAD_MARK on Start.
  - LEAD_MARK → LEAD_SPACE.
  - LEAD_SPACE → BIT_MARK for a full frame (bit index = 0).
  - LEAD_SPACE → STOP_MARK for a repeat code.
  - BIT_MARK → BIT_SPACE.
  - BIT_SPACE → BIT_MARK with index+1 if index < 31; otherwise → STOP_MARK.
  - STOP_MARK → IDLE, with Done=1 for one cycle.
- Latency: Start sampled at edge N puts Envelope=1 and Busy=1 on the outputs from edge N+1.
- Envelope is 1 in LEAD_MARK, BIT_MARK and STOP_MARK, and 0 elsewhere.
- Carrier:
  - The carrier counter and phase are reset at every mark entry, so IrOut goes high on the first mark cycle.
  - The phase toggles every CAR_HALF cycles.
  - IrOut = Envelope AND phase; IrOut is 0 in spaces and in IDLE.
- Start while Busy is ignored; Addr, Cmd and Repeat changes during a frame have no effect.
- Start in the same cycle as Done (state already IDLE) is accepted, so frames run back to back.
- Start and Repeat are sampled together; Repeat has no effect without Start.
- Width rules:
  - Unit counter: clog2(UNIT_CYC) bits.
  - Unit-count register: 5 bits (maximum 16).
  - Bit index: 5 bits.
  - Carrier counter: clog2(CAR_HALF) bits.
  - All counters are unsigned and wrap-free by construction.

Decomposition:
- Shared package nec_pkg:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK);
  - unit-count constants (16/8/4/1/3/1);
  - default UNIT_CYC/CAR_HALF values for 50 MHz.
- Sub-module nec_carrier_gen: carrier counter and phase, with an enable tied to Envelope and a restart input on mark entry.
- The FSM and timebase stay in nec_ir_tx.

Test Plan:
All scenarios use UNIT_CYC=8 and CAR_HALF=2.
1. Reset: hold RST_n=0 for 3 cycles while Start=1 → IrOut, Envelope, Busy and Done all stay 0; no frame starts.
2. Full frame, Addr=0x00, Cmd=0x45, Repeat=0:
   - Envelope high for 128 cycles, then low for 64.
   - 32 bits decode to F=0xBA45FF00, sent LSB first.
   - Busy is high for exactly 968 cycles, then Done pulses for one cycle.
3. Repeat code, Start with Repeat=1 → mark 128 cycles, space 32, stop mark 8; Busy high for 168 cycles; Done pulse.
4. Carrier: during the leader mark, IrOut follows the pattern 1,1,0,0 repeating, starting at the first mark cycle; IrOut is 0 during all spaces.
5. Start pulses mid-frame with different Addr/Cmd → ignored; the frame content and length are unchanged. A Start coincident with Done is accepted, and Envelope rises on the next cycle.
6. RST_n=0 during bit 10 → all outputs are 0 the next cycle and no Done is generated. A new Start after reset sends a clean full frame.
